// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-ported data memory between FU loads and committed LSQ stores.
// mem_st_lsq = {addr[31:0], ps2_data[31:0], sw_sh_signal}. Define DMEM_ARB_STATS_EN for counters.
module dmem_port_arbiter #(
  parameter int unsigned TAG_W      = 7,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_func3,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             st_is_half,
  output logic             mem_ld_issue,
  output logic [31:0]      mem_addr,
  output logic [2:0]       mem_func3,
  output logic             mem_st_wb,
  output logic [64:0]      mem_st_lsq,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             ld_resp_valid,
  output logic [31:0]      ld_resp_data,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic             busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]      stat_loads,
  output logic [31:0]      stat_stores,
  output logic [31:0]      stat_starve_forces
`endif
);

  localparam int unsigned CntW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  typedef enum logic [0:0] {StPri, StLdPri} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               starve_cnt_q, starve_cnt_d;
  logic [RD_LAT-1:0]             pipe_valid_q, pipe_valid_d;
  logic [RD_LAT-1:0]             pipe_issued_q, pipe_issued_d;
  logic [RD_LAT-1:0]             pipe_ok_q, pipe_ok_d;
  logic [RD_LAT-1:0][TAG_W-1:0]  pipe_tag_q, pipe_tag_d;

  logic ld_grant, st_grant, func3_ok;

  assign func3_ok = (ld_func3 == 3'b100) || (ld_func3 == 3'b010);

  // Stores win by default; a starved load gets one forced grant. Flush blocks new loads.
  always_comb begin
    ld_grant = 1'b0;
    st_grant = 1'b0;
    if (!reset) begin
      if (state_q == StLdPri) begin
        ld_grant = ld_req_valid & ~flush;
        st_grant = st_req_valid & ~ld_grant;
      end else begin
        st_grant = st_req_valid;
        ld_grant = ld_req_valid & ~st_req_valid & ~flush;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (!ld_req_valid || ld_grant) begin
      state_d      = StPri;
      starve_cnt_d = '0;
    end else if (state_q == StPri) begin
      if (starve_cnt_q == CntW'(STARVE_MAX - 1)) begin
        state_d      = StLdPri;
        starve_cnt_d = '0;
      end else begin
        starve_cnt_d = starve_cnt_q + CntW'(1);
      end
    end
  end

  // pipe_issued mirrors pipe_valid but survives flush: memory still answers squashed loads.
  always_comb begin
    pipe_valid_d  = pipe_valid_q;
    pipe_issued_d = pipe_issued_q;
    pipe_ok_d     = pipe_ok_q;
    pipe_tag_d    = pipe_tag_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_valid_d[i]  = pipe_valid_q[i-1];
      pipe_issued_d[i] = pipe_issued_q[i-1];
      pipe_ok_d[i]     = pipe_ok_q[i-1];
      pipe_tag_d[i]    = pipe_tag_q[i-1];
    end
    pipe_valid_d[0]  = ld_grant;
    pipe_issued_d[0] = ld_grant;
    pipe_ok_d[0]     = func3_ok;
    pipe_tag_d[0]    = ld_tag;
    if (flush) pipe_valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StPri;
      starve_cnt_q  <= '0;
      pipe_valid_q  <= '0;
      pipe_issued_q <= '0;
      pipe_ok_q     <= '0;
      pipe_tag_q    <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_issued_q <= pipe_issued_d;
      pipe_ok_q     <= pipe_ok_d;
      pipe_tag_q    <= pipe_tag_d;
    end
  end

  always_comb begin
    ld_req_ready  = ld_grant;
    st_req_ready  = st_grant;
    mem_ld_issue  = ld_grant;
    mem_addr      = ld_grant ? ld_addr : '0;
    mem_func3     = ld_grant ? ld_func3 : '0;
    mem_st_wb     = st_grant;
    mem_st_lsq    = st_grant ? {st_addr, st_data, st_is_half} : '0;
    ld_resp_valid = ~reset & ~flush & pipe_valid_q[RD_LAT-1] & mem_rvalid;
    ld_resp_data  = (ld_resp_valid && pipe_ok_q[RD_LAT-1]) ? mem_rdata : '0;
    ld_resp_tag   = ld_resp_valid ? pipe_tag_q[RD_LAT-1] : '0;
    busy          = ~reset & ((|pipe_valid_q) | st_req_valid);
  end

  a_one_grant : assert property (@(posedge clk) !(ld_req_ready && st_req_ready));
  a_rvalid_match : assert property (@(posedge clk) disable iff (reset)
    mem_rvalid == pipe_issued_q[RD_LAT-1]);

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_forces_q, stat_forces_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    stat_loads_d  = sat_inc(stat_loads_q, ld_grant);
    stat_stores_d = sat_inc(stat_stores_q, st_grant);
    stat_forces_d = sat_inc(stat_forces_q, (state_q == StPri) && (state_d == StLdPri));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_forces_q <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_forces_q <= stat_forces_d;
    end
  end

  assign stat_loads         = stat_loads_q;
  assign stat_stores        = stat_stores_q;
  assign stat_starve_forces = stat_forces_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: arbitration table, directed corner sequences and random
// traffic against a behavioural memory plus an in-flight load scoreboard.
module tb_dmem_port_arbiter;

  localparam int TAG_W      = 7;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1, flush = 1'b0;
  logic             ld_req_valid = 1'b0, st_req_valid = 1'b0, st_is_half = 1'b0;
  logic [31:0]      ld_addr = '0, st_addr = '0, st_data = '0, mem_rdata = '0;
  logic [2:0]       ld_func3 = '0;
  logic [TAG_W-1:0] ld_tag = '0;
  logic             mem_rvalid = 1'b0;
  logic             ld_req_ready, st_req_ready, mem_ld_issue, mem_st_wb, ld_resp_valid, busy;
  logic [31:0]      mem_addr, ld_resp_data;
  logic [2:0]       mem_func3;
  logic [64:0]      mem_st_lsq;
  logic [TAG_W-1:0] ld_resp_tag;

  dmem_port_arbiter #(.TAG_W(TAG_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_addr(ld_addr),
    .ld_func3(ld_func3), .ld_tag(ld_tag),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_addr(st_addr),
    .st_data(st_data), .st_is_half(st_is_half),
    .mem_ld_issue(mem_ld_issue), .mem_addr(mem_addr), .mem_func3(mem_func3),
    .mem_st_wb(mem_st_wb), .mem_st_lsq(mem_st_lsq), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .ld_resp_tag(ld_resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int losses = 0;

  // Memory: 64 words, read data captured at issue and returned RD_LAT cycles later.
  logic [31:0] mem_words [64];
  logic        mp_v0 = 1'b0, mp_v1 = 1'b0;
  logic [31:0] mp_d0 = '0, mp_d1 = '0;

  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } inflight_t;
  inflight_t infl[$];

  logic             s_ld_rdy, s_st_rdy, s_st_wb, s_rv, s_busy, s_issue;
  logic [31:0]      s_rdata;
  logic [TAG_W-1:0] s_rtag;

  typedef struct packed {
    logic st_v;
    logic ld_v;
    logic fl;
    logic exp_st;
    logic exp_ld;
  } vec_t;

  function automatic vec_t mk(logic s, logic l, logic f, logic es, logic el);
    vec_t v;
    v.st_v = s; v.ld_v = l; v.fl = f; v.exp_st = es; v.exp_ld = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = mem_words[a[7:2]];
    if (f3 == 3'b100) return {24'h0, w[8*int'(a[1:0]) +: 8]};
    return w;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic half);
    if (half) mem_words[a[7:2]][16*int'(a[1]) +: 16] = d[15:0];
    else mem_words[a[7:2]] = d;
  endtask

  task automatic idle();
    flush = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
  endtask

  task automatic set_ld(input logic [31:0] a, input logic [2:0] f3, input logic [TAG_W-1:0] t);
    ld_req_valid = 1'b1; ld_addr = a; ld_func3 = f3; ld_tag = t;
  endtask

  task automatic set_st(input logic [31:0] a, input logic [31:0] d, input logic half);
    st_req_valid = 1'b1; st_addr = a; st_data = d; st_is_half = half;
  endtask

  // One clock: drive memory response, check at negedge against the model, advance models.
  task automatic run_cycle();
    logic             exp_ld, exp_st, exp_rv, exp_busy, ok;
    logic [TAG_W-1:0] exp_tag;
    logic [31:0]      exp_data;
    inflight_t        e;
    mem_rvalid = mp_v1;
    mem_rdata  = mp_v1 ? mp_d1 : $urandom();
    @(negedge clk);
    exp_ld = 1'b0; exp_st = 1'b0; exp_rv = 1'b0; exp_busy = 1'b0;
    exp_tag = '0; exp_data = '0;
    if (!reset) begin
      if (losses >= STARVE_MAX) begin
        exp_ld = ld_req_valid && !flush;
        exp_st = st_req_valid && !exp_ld;
      end else begin
        exp_st = st_req_valid;
        exp_ld = ld_req_valid && !st_req_valid && !flush;
      end
      exp_busy = st_req_valid || (infl.size() != 0);
      if (infl.size() != 0 && infl[0].due == cyc && !flush) begin
        exp_rv = 1'b1; exp_tag = infl[0].tag; exp_data = infl[0].data;
      end
    end
    chk("ld_req_ready", ld_req_ready, exp_ld);
    chk("st_req_ready", st_req_ready, exp_st);
    chk("mem_ld_issue", mem_ld_issue, exp_ld);
    chk("mem_st_wb", mem_st_wb, exp_st);
    chk("ld_resp_valid", ld_resp_valid, exp_rv);
    chk("busy", busy, exp_busy);
    if (exp_ld) begin
      chk("mem_addr", mem_addr, ld_addr);
      chk("mem_func3", mem_func3, ld_func3);
    end
    if (exp_st) chk("mem_st_lsq", mem_st_lsq, {st_addr, st_data, st_is_half});
    if (exp_rv) begin
      chk("ld_resp_data", ld_resp_data, exp_data);
      chk("ld_resp_tag", ld_resp_tag, exp_tag);
    end
    s_ld_rdy = ld_req_ready; s_st_rdy = st_req_ready; s_st_wb = mem_st_wb;
    s_rv = ld_resp_valid; s_busy = busy; s_issue = mem_ld_issue;
    s_rdata = ld_resp_data; s_rtag = ld_resp_tag;
    if (mem_st_wb) mem_wr(mem_st_lsq[64:33], mem_st_lsq[32:1], mem_st_lsq[0]);
    mp_v1 = mp_v0; mp_d1 = mp_d0;
    mp_v0 = mem_ld_issue; mp_d0 = mem_rd(mem_addr, mem_func3);
    if (reset) begin
      infl.delete(); losses = 0; mp_v0 = 1'b0; mp_v1 = 1'b0;
    end else begin
      if (infl.size() != 0 && infl[0].due == cyc) void'(infl.pop_front());
      if (flush) infl.delete();
      if (exp_ld) begin
        ok = (ld_func3 == 3'b100) || (ld_func3 == 3'b010);
        e.due = cyc + RD_LAT; e.tag = ld_tag; e.data = ok ? mem_rd(ld_addr, ld_func3) : 32'h0;
        infl.push_back(e);
      end
      losses = (ld_req_valid && !exp_ld) ? losses + 1 : 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl [22];

  initial begin
    for (int i = 0; i < 64; i++) mem_words[i] = $urandom();
    // Fresh arbitration sequence: 4 store wins then one forced load; flush blocks the load.
    tbl[0]  = mk(1, 1, 0, 1, 0);  tbl[1]  = mk(1, 1, 0, 1, 0);
    tbl[2]  = mk(1, 1, 0, 1, 0);  tbl[3]  = mk(1, 1, 0, 1, 0);
    tbl[4]  = mk(1, 1, 0, 0, 1);  tbl[5]  = mk(1, 1, 0, 1, 0);
    tbl[6]  = mk(1, 1, 0, 1, 0);  tbl[7]  = mk(1, 1, 0, 1, 0);
    tbl[8]  = mk(1, 1, 0, 1, 0);  tbl[9]  = mk(1, 1, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 1);  tbl[11] = mk(1, 0, 0, 1, 0);
    tbl[12] = mk(1, 1, 0, 1, 0);  tbl[13] = mk(0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 1, 1, 0);  tbl[15] = mk(1, 1, 1, 1, 0);
    tbl[16] = mk(1, 1, 1, 1, 0);  tbl[17] = mk(1, 1, 1, 1, 0);
    tbl[18] = mk(1, 1, 1, 1, 0);  tbl[19] = mk(1, 1, 0, 0, 1);
    tbl[20] = mk(0, 1, 1, 0, 0);  tbl[21] = mk(0, 0, 0, 0, 0);

    idle(); reset = 1'b1;
    run_cycle(); run_cycle();
    reset = 1'b0;
    run_cycle();
    chk("reset.ld_ready", s_ld_rdy, 1'b0);
    chk("reset.resp_valid", s_rv, 1'b0);
    chk("reset.busy", s_busy, 1'b0);

    for (int i = 0; i < 22; i++) begin
      idle();
      if (tbl[i].st_v) set_st(32'h80 + 32'(4 * i), $urandom(), 1'b0);
      if (tbl[i].ld_v) set_ld(32'(4 * i), 3'b010, TAG_W'(i));
      flush = tbl[i].fl;
      run_cycle();
      chk($sformatf("tbl[%0d].st_ready", i), s_st_rdy, tbl[i].exp_st);
      chk($sformatf("tbl[%0d].ld_ready", i), s_ld_rdy, tbl[i].exp_ld);
    end
    idle(); run_cycle(); run_cycle();

    // Load only
    mem_words[4] = 32'hDEADBEEF;
    set_ld(32'h10, 3'b010, 7'd5); run_cycle();
    chk("load_only.issue", s_issue, 1'b1);
    idle(); run_cycle();
    chk("load_only.early", s_rv, 1'b0);
    run_cycle();
    chk("load_only.valid", s_rv, 1'b1);
    chk("load_only.data", s_rdata, 32'hDEADBEEF);
    chk("load_only.tag", s_rtag, 7'd5);

    // Store then byte load next cycle
    set_st(32'h20, 32'h12345678, 1'b0); run_cycle();
    chk("order.st_wb", s_st_wb, 1'b1);
    idle(); set_ld(32'h20, 3'b100, 7'd3); run_cycle();
    idle(); run_cycle(); run_cycle();
    chk("order.valid", s_rv, 1'b1);
    chk("order.data", s_rdata, 32'h00000078);
    chk("order.tag", s_rtag, 7'd3);

    // Flush kills two in-flight loads; a store in the flush cycle still drains
    set_ld(32'h10, 3'b010, 7'd1); run_cycle();
    set_ld(32'h14, 3'b010, 7'd2); run_cycle();
    idle(); flush = 1'b1; set_st(32'h40, 32'hCAFEF00D, 1'b0); run_cycle();
    chk("flush.st_wb", s_st_wb, 1'b1);
    chk("flush.resp1", s_rv, 1'b0);
    idle(); run_cycle();
    chk("flush.resp2", s_rv, 1'b0);
    run_cycle();
    set_ld(32'h40, 3'b010, 7'd9); run_cycle();
    idle(); run_cycle(); run_cycle();
    chk("flush_st.valid", s_rv, 1'b1);
    chk("flush_st.data", s_rdata, 32'hCAFEF00D);

    // Unsupported func3 returns zero data
    set_ld(32'h10, 3'b000, 7'h2A); run_cycle();
    idle(); run_cycle(); run_cycle();
    chk("func3.valid", s_rv, 1'b1);
    chk("func3.data", s_rdata, 32'h0);
    chk("func3.tag", s_rtag, 7'h2A);

    // Reset with two loads in flight
    set_ld(32'h10, 3'b010, 7'd1); run_cycle();
    set_ld(32'h14, 3'b010, 7'd2); run_cycle();
    idle(); reset = 1'b1; run_cycle();
    reset = 1'b0; run_cycle();
    chk("rst_inflight.resp", s_rv, 1'b0);
    chk("rst_inflight.busy", s_busy, 1'b0);
    chk("rst_inflight.issue", s_issue, 1'b0);
    run_cycle();
    chk("rst_inflight.resp2", s_rv, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      ld_req_valid = ($urandom_range(0, 2) != 0);
      ld_addr      = {24'h0, 8'($urandom())};
      case ($urandom_range(0, 3))
        0:       ld_func3 = 3'b100;
        1:       ld_func3 = 3'b010;
        2:       ld_func3 = 3'b000;
        default: ld_func3 = 3'($urandom());
      endcase
      ld_tag       = TAG_W'($urandom());
      st_req_valid = 1'($urandom_range(0, 1));
      st_addr      = {24'h0, 8'($urandom())};
      st_data      = $urandom();
      st_is_half   = 1'($urandom_range(0, 1));
      run_cycle();
    end
    reset = 1'b0; idle();
    run_cycle(); run_cycle(); run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
